// File: rtl/test_mem.sv
// Wait-state test memory: single-port RAM with a write-protected ROM window,
// programmable wait states, a sticky ROM-write error flag and an access counter.
module test_mem #(
  parameter int unsigned    AW       = 16,
  parameter int unsigned    DW       = 8,
  parameter int unsigned    WAIT     = 0,
  parameter logic [AW-1:0]  ROM_BASE = AW'(16'hE000),
  parameter int unsigned    CW       = 16
) (
  input  logic          ph1,
  input  logic          reset_b,
  input  logic          req,
  input  logic          read_en,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          busy,
  output logic          rom_wr_err,
  output logic [CW-1:0] acc_count
);

  localparam int unsigned     DEPTH     = 1 << AW;
  localparam int unsigned     WCW       = 4;
  localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(WAIT);
  localparam bit              HAS_WAIT  = (WAIT != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [1:0]     next_state;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wcnt_nxt;

  logic [AW-1:0]  lat_addr;
  logic [DW-1:0]  lat_wdata;
  logic           lat_rd;

  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_rd;
  logic           enter_done;
  logic           is_rom;

  logic [DW-1:0]  mem [DEPTH];

  // With no wait states DONE is entered on the acceptance edge, so the
  // access must use the live request fields rather than the latched copy.
  assign sel_addr   = (state == S_IDLE) ? address : lat_addr;
  assign sel_wdata  = (state == S_IDLE) ? wdata   : lat_wdata;
  assign sel_rd     = (state == S_IDLE) ? read_en : lat_rd;
  assign enter_done = (next_state == S_DONE) && (state != S_DONE);
  assign is_rom     = (sel_addr >= ROM_BASE);

  // Next-state and wait-counter logic
  always_comb begin
    next_state = state;
    wcnt_nxt   = wcnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          wcnt_nxt   = WAIT_LOAD;
          next_state = HAS_WAIT ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        wcnt_nxt = wcnt - WCW'(1);
        if (wcnt == WCW'(1)) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
        wcnt_nxt   = '0;
      end
    endcase
  end

  // State, request latches and registered outputs
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_rd     <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      rom_wr_err <= 1'b0;
      acc_count  <= '0;
      rdata      <= '0;
    end else begin
      state <= next_state;
      wcnt  <= wcnt_nxt;
      ready <= (state == S_DONE);
      busy  <= (next_state != S_IDLE);
      if ((state == S_IDLE) && req) begin
        lat_addr  <= address;
        lat_wdata <= wdata;
        lat_rd    <= read_en;
      end
      if (enter_done) begin
        acc_count <= acc_count + CW'(1);
        if (sel_rd) begin
          rdata <= mem[sel_addr];
        end else if (is_rom) begin
          rom_wr_err <= 1'b1;
        end
      end
    end
  end

  // Storage is never reset; reset_b gates off any write on an aborted access
  always_ff @(posedge ph1) begin
    if (reset_b && enter_done && !sel_rd && !is_rom) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

endmodule
